fetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the decode/register-read stage. It issues sequential word fetches to the synchronous instruction memory and buffers returned instructions with their PCs. It hands them downstream over a valid/ready handshake. It accepts redirects (branch/jump targets) from the execute stage and stops fetching after a HALT instruction has been queued.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, opcode constants, fetch FSM states, fetch queue entry.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;

  // Major opcodes live in inst[31:26].
  localparam logic [5:0] OP_ALU    = 6'd0;
  localparam logic [5:0] OP_LOAD   = 6'd1;
  localparam logic [5:0] OP_STORE  = 6'd2;
  localparam logic [5:0] OP_BRANCH = 6'd4;
  localparam logic [5:0] OP_JUMP   = 6'd5;
  localparam logic [5:0] OP_HALT   = 6'd63;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One prefetch queue slot: the PC travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [XLEN-1:0] inst);
    return inst[31:26] == OP_HALT;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input, decode-side valid/ready output.
// Latency: n/a (wires only).
// Backpressure: out_ready from the slave side stalls the queue head.
// Ports: master = fetch unit side, slave = memory/execute/decode environment side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x WIDTH circular buffer with synchronous clear and combinational head.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer must never push into a full queue.
// Ports: clk/rst, i_push/i_push_dat, i_pop, i_clr (wins over push/pop), o_head_dat, o_count, o_empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_clr,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !i_clr;
  assign w_do_pop  = i_pop && !i_clr && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      // Dropping everything only needs the read pointer to catch up.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_do_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch into a DEPTH-entry prefetch queue, with redirect and HALT stop.
// Latency: request to out_valid is 2 cycles; redirect at t gives target request at t+1, out_valid at t+3.
// Backpressure: out_ready low fills the queue; requests stop once queued + in-flight reaches DEPTH.
// Ports: clk, rst (async, active-low), bus (fetch_unit_if.master), stat_fetched, stat_flushed.
// Build option: define FETCH_STATS_EN to build the pushed/flushed counters; otherwise both read 0.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    bus,
  output logic [XLEN-1:0] stat_fetched,
  output logic [XLEN-1:0] stat_flushed
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;
  logic            w_room;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_halt_push;

  // Reserve a slot for the response still on its way so a push can never overflow.
  assign w_room = (32'(w_count) + 32'(r_inflight)) < 32'(DEPTH);

  // rst in the term keeps imem_req low while reset is held.
  assign w_req = rst && (r_state == RUN) && !bus.redirect_valid && w_room;

  // A response arriving in a redirect cycle is discarded.
  assign w_push      = r_inflight && !bus.redirect_valid;
  assign w_halt_push = w_push && is_halt(bus.imem_rdata);

  // A pop coinciding with a redirect is void; the clear takes the whole queue.
  assign w_pop = !w_empty && bus.out_ready && !bus.redirect_valid;

  assign w_push_dat = '{pc: r_inflight_pc, inst: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_clr      (bus.redirect_valid),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= word_align(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      // The request issued alongside a HALT push is younger than the HALT: kill it.
      r_inflight <= w_req && !w_halt_push;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (bus.redirect_valid) begin
        r_state    <= RUN;
        r_fetch_pc <= word_align(bus.redirect_pc);
      end else begin
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_halt_push) begin
          r_state <= HALTED;
        end
      end
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_inst  = w_head.inst;

`ifdef FETCH_STATS_EN
  logic [XLEN-1:0] r_stat_fetched;
  logic [XLEN-1:0] r_stat_flushed;
  logic [XLEN-1:0] w_flush_inc;

  // Redirect discards the queue plus any arriving response; HALT discards the request issued beside it.
  always_comb begin
    w_flush_inc = '0;
    if (bus.redirect_valid) begin
      w_flush_inc = 32'(w_count) + 32'(r_inflight);
    end else if (w_halt_push && w_req) begin
      w_flush_inc = 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      r_stat_fetched <= r_stat_fetched + 32'(w_push);
      r_stat_flushed <= r_stat_flushed + w_flush_inc;
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`else
  assign stat_fetched = '0;
  assign stat_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model, directed scenarios, then randomized traffic.
// Latency: n/a.
// Backpressure: out_ready driven by the bench.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] mem [256];

  // Reference model state: what the stage should hold, in queue terms.
  ent_t        m_q[$];
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          first_vld_cyc;
  logic [31:0] got_pc[$];
  bit          last_req;
  logic [31:0] last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic init_mem(input bit with_halts);
    for (int i = 0; i < 256; i++) begin
      int op;
      op = $urandom_range(0, 62);
      if (with_halts && $urandom_range(0, 24) == 0) op = 63;
      mem[i] = {6'(op), 18'($urandom()), 8'(i)};
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run     = 1'b1;
    m_pc      = RESET_PC;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_fetched = '0;
    m_flushed = '0;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it two cycles later.
  task automatic reset_dut();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    bus.imem_rdata     = $urandom();
    #1;
    check("rst_imem_req",  32'(bus.imem_req),  32'd0);
    check("rst_imem_addr", bus.imem_addr,      RESET_PC);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc",    bus.out_pc,         32'd0);
    check("rst_out_inst",  bus.out_inst,       32'd0);
    check("rst_fetched",   stat_fetched,       32'd0);
    check("rst_flushed",   stat_flushed,       32'd0);
    model_reset();
    last_req      = 1'b0;
    first_vld_cyc = -1;
    got_pc.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit ordy);
    bit   exp_req;
    bit   exp_vld;
    bit   new_pend;
    ent_t r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    bus.imem_rdata     = last_req ? mem[last_addr[9:2]] : $urandom();
    #1;
    exp_vld = (m_q.size() != 0);
    exp_req = m_run && !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
    check("out_valid", 32'(bus.out_valid), 32'(exp_vld));
    check("imem_req",  32'(bus.imem_req),  32'(exp_req));
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    if (exp_vld) begin
      check("out_pc",   bus.out_pc,   m_q[0].pc);
      check("out_inst", bus.out_inst, m_q[0].inst);
    end
    check("stat_fetched", stat_fetched, STATS_EN ? m_fetched : 32'd0);
    check("stat_flushed", stat_flushed, STATS_EN ? m_flushed : 32'd0);
    if (bus.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (bus.out_valid && ordy && !rv) got_pc.push_back(bus.out_pc);
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;

    if (rv) begin
      m_flushed = m_flushed + 32'(m_q.size()) + 32'(m_pend);
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
      m_run  = 1'b1;
    end else begin
      if (exp_vld && ordy) void'(m_q.pop_front());
      new_pend = exp_req;
      if (m_pend) begin
        r.pc   = m_pend_pc;
        r.inst = mem[m_pend_pc[9:2]];
        m_q.push_back(r);
        m_fetched = m_fetched + 32'd1;
        if (r.inst[31:26] == 6'd63) begin
          m_run = 1'b0;
          if (exp_req) begin
            m_flushed = m_flushed + 32'd1;
            new_pend  = 1'b0;
          end
        end
      end
      m_pend_pc = m_pc;
      m_pend    = new_pend;
      if (exp_req) m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int n0;
    int nreq;
    int nstale;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    last_req = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    bus.imem_rdata     = '0;
    init_mem(1'b0);
    @(negedge clk);

    // Streaming with out_ready high.
    reset_dut();
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1);
    check("t1_first_valid_cycle", 32'(first_vld_cyc), 32'd2);
    check("t1_delivered_ge8", 32'(got_pc.size() >= 8), 32'd1);
    if (got_pc.size() >= 8)
      for (int i = 0; i < 8; i++) check("t1_pc_order", got_pc[i], 32'(i * 4));

    // Stall for 10 cycles, then release.
    reset_dut();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    #1;
    check("t2_req_held_low", 32'(bus.imem_req), 32'd0);
    check("t2_none_delivered", 32'(got_pc.size()), 32'd0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1);
    check("t2_delivered_ge8", 32'(got_pc.size() >= 8), 32'd1);
    if (got_pc.size() >= 8)
      for (int i = 0; i < 8; i++) check("t2_pc_order", got_pc[i], 32'(i * 4));

    // Redirect with a full queue.
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    t = cyc;
    step(1'b1, 32'h40, 1'b1);
    first_vld_cyc = -1;
    n0 = got_pc.size();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check("t3_valid_rise", 32'(first_vld_cyc), 32'(t + 3));
    check("t3_delivered", 32'(got_pc.size() > n0), 32'd1);
    if (got_pc.size() > n0) check("t3_first_pc", got_pc[n0], 32'h40);

    // Misaligned redirect target.
    step(1'b1, 32'h102, 1'b1);
    bus.redirect_valid = 1'b0;
    #1;
    check("t4_req", 32'(bus.imem_req), 32'd1);
    check("t4_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // HALT at 0xC.
    mem[3][31:26] = 6'd63;
    reset_dut();
    nreq = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b1);
      if (i >= 10 && last_req) nreq++;
    end
    check("t5_req_quiet", 32'(nreq), 32'd0);
    check("t5_delivered", 32'(got_pc.size()), 32'd4);
    if (got_pc.size() == 4)
      for (int i = 0; i < 4; i++) check("t5_pc_order", got_pc[i], 32'(i * 4));
    step(1'b1, 32'h0, 1'b1);
    bus.redirect_valid = 1'b0;
    #1;
    check("t5_restart_req", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Redirect in the cycle the HALT response returns.
    reset_dut();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h80, 1'b1);
    check("t6_fetched", stat_fetched, STATS_EN ? 32'd3 : 32'd0);
    check("t6_flushed", stat_flushed, STATS_EN ? 32'd2 : 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    nstale = 0;
    foreach (got_pc[i]) if (got_pc[i] == 32'hC) nstale++;
    check("t6_halt_not_delivered", 32'(nstale), 32'd0);
    check("t6_delivered_ge3", 32'(got_pc.size() >= 3), 32'd1);
    if (got_pc.size() >= 3) check("t6_target_pc", got_pc[2], 32'h80);

    // Randomized traffic, address wrap and a mid-run reset.
    init_mem(1'b1);
    reset_dut();
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 1600; i++) begin
      bit          rv;
      logic [31:0] rpc;
      if (i == 800) reset_dut();
      rv  = ($urandom_range(0, 31) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
      step(rv, rpc, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
